// File: rtl/branch_seq_pkg.sv
// Shared types for the branch PC sequencer: decoded op codes, FSM states and default widths.
package branch_seq_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 19;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BRQ  = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular-buffer return-address stack; a push onto a full stack overwrites the oldest entry.
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf_pulse
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W:0]   count;

  // When full, wr_ptr has wrapped onto the oldest slot, so a push naturally replaces it.
  assign top_ptr   = wr_ptr - PTR_W'(1);
  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign ovf_pulse = push && full;
  assign dout      = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) begin
        count <= count + (PTR_W+1)'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/branch_pc_sequencer.sv
// PC sequencer: drives the fetch handshake, resolves SEQ/BRQ/JMP/CALL/RET/HALT and owns the return stack.
module branch_pc_sequencer
  import branch_seq_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ready,
  input  logic              instr_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] r_a,
  input  logic [DATA_W-1:0] r_b,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic              halted,
  output logic              ras_ovf,
  output logic              ras_unf
);

  state_e            state;
  state_e            state_next;
  logic              started;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] seq_pc;
  logic              redirect;
  logic              push;
  logic              pop;
  logic              unf_set;
  logic [ADDR_W-1:0] ras_dout;
  logic              ras_empty;
  logic              ras_full;
  logic              ovf_pulse;

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .din       (seq_pc),
    .dout      (ras_dout),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf_pulse (ovf_pulse)
  );

  // started keeps fetch_valid low for the first cycle out of reset.
  assign seq_pc      = pc + ADDR_W'(1);
  assign fetch_valid = (state == ST_FETCH) && started;
  assign fetch_addr  = pc;
  assign halted      = (state == ST_HALT);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    redirect   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    unf_set    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (started && fetch_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (instr_valid) begin
          state_next = ST_FETCH;
          pc_next    = seq_pc;
          case (op)
            OP_BRQ: begin
              if (r_a == r_b) begin
                pc_next  = target;
                redirect = 1'b1;
              end
            end
            OP_JMP: begin
              pc_next  = target;
              redirect = 1'b1;
            end
            OP_CALL: begin
              push     = 1'b1;
              pc_next  = target;
              redirect = 1'b1;
            end
            OP_RET: begin
              if (!ras_empty) begin
                pop      = 1'b1;
                pc_next  = ras_dout;
                redirect = 1'b1;
              end else begin
                unf_set = 1'b1;
              end
            end
            OP_HALT: begin
              pc_next    = pc;
              state_next = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: ;
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      started <= 1'b0;
      flush   <= 1'b0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_next;
      pc      <= pc_next;
      flush   <= redirect;
      if (ovf_pulse) ras_ovf <= 1'b1;
      if (unf_set)   ras_unf <= 1'b1;
    end
  end

endmodule
